frame_scheduler: RTL and testbench
==================================

Name: frame_scheduler

Overview:
- Sequences the per-frame pixel-writer engines (one clear engine plus N_OBJ object drawers) onto the single framebuffer write port.
- On each frame tick it runs the clear engine first, then each enabled object drawer in ascending index order, then idles until the next tick.
- Muxes the active engine's x/y onto the write port, drives color, and reports overruns and hung drawers.

Parameters:
N_OBJ, 4, number of object drawer engines (1..8)
COORD_W, 11, coordinate width
TIMEOUT, 65535, max cycles a drawer may stay enabled before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
frame_tick  in  1  one-cycle pulse, start of vblank
obj_valid  in  N_OBJ  per-object draw enable
clr_en  out  1  level enable to clear engine
clr_done  in  1  clear engine finished (one-cycle pulse)
clr_x, clr_y  in  COORD_W each  clear engine coordinates
obj_en  out  N_OBJ  one-hot level enable to object drawers
obj_done  in  N_OBJ  per-drawer finished pulse
obj_x, obj_y  in  N_OBJ*COORD_W each  packed drawer coordinates, index i at [i*COORD_W +: COORD_W]
x, y  out  COORD_W each  write-port coordinates
color  out  1  0 = clear/background, 1 = object
wr_en  out  1  write strobe
busy  out  1  high from CLEAR entry until WAIT_FRAME/IDLE
overrun_cnt  out  8  saturating count of ticks arriving while busy
timeout_err  out  1  sticky; a drawer hit TIMEOUT

Behaviour:
- Reset (asynchronous, reset==0): state IDLE. All outputs 0. Pending tick cleared, snapshot cleared, timeout counter cleared. Reset mid-frame aborts immediately; no further writes occur.
- States: IDLE, CLEAR, SCAN, DRAW, WAIT_FRAME. IDLE and WAIT_FRAME behave identically; IDLE is only the post-reset state.
- IDLE/WAIT_FRAME -> CLEAR:
  - Occurs the cycle after frame_tick==1, or immediately if a pending tick is latched.
  - On entry, obj_valid is snapshotted into vmask. Changes to obj_valid mid-frame take effect next frame.
- CLEAR:
  - clr_en=1, wr_en=1, color=0, x/y=clr_x/clr_y.
  - On clr_done: go to SCAN with cur=-1, i.e. search starts at index 0.
- SCAN: one cycle, wr_en=0, all enables 0.
  - Picks the lowest index j>cur with vmask[j]=1.
  - If found: DRAW with sel=j. Otherwise: WAIT_FRAME.
- DRAW:
  - obj_en[sel]=1 (only that bit), wr_en=1, color=1, x/y=obj_x/obj_y slice sel.
  - On obj_done[sel]: go to SCAN with cur=sel. obj_done bits for other indices are ignored.
  - Timeout counter clears on DRAW entry and increments each DRAW cycle. If it reaches TIMEOUT-1 without done: set timeout_err, go to SCAN with cur=sel (skip the hung drawer). The aborting cycle still writes.
- busy=1 in CLEAR, SCAN, DRAW.
- frame_tick while busy:
  - Latch pending=1 and increment overrun_cnt, saturating at 255.
  - Multiple ticks while busy still leave a single pending tick (each one counts).
  - On reaching WAIT_FRAME with pending=1: go to CLEAR next cycle and clear pending.
  - A tick in the same cycle as the WAIT_FRAME transition counts as an overrun and becomes pending.
- Simultaneous clr_done and frame_tick: the tick is an overrun.
- vmask all zero: CLEAR -> SCAN -> WAIT_FRAME.
- x/y/color are registered-free combinational muxes of the current state. wr_en and enables derive from the registered state only (no comb path from done to enable).
- timeout_err and overrun_cnt clear only on reset.

Decomposition:
- Package frame_sched_pkg holds:
  - state enum (IDLE, CLEAR, SCAN, DRAW, WAIT_FRAME)
  - COORD_W default
  - color constants COLOR_BG=0, COLOR_OBJ=1
- Sub-module obj_picker: combinational. Inputs vmask and cur. Outputs found and next index. Lowest set bit above cur.

Test Plan:
- Reset 0 at t0, tick at t5, vmask=4'b0101, clr_done at t20, drawer dones after 10 cycles each.
  - CLEAR t6..t20, SCAN t21, DRAW sel=0 t22..t31, SCAN, DRAW sel=2, SCAN, WAIT_FRAME.
  - obj_en[1] and obj_en[3] never high.
  - color=0 only in CLEAR.
- obj_valid=0, tick -> CLEAR, SCAN, WAIT_FRAME. obj_en stays 0. busy falls after 2 cycles past clr_done.
- Three ticks during one frame -> overrun_cnt=3. After WAIT_FRAME, immediate CLEAR once, not three times. 300 ticks while busy -> overrun_cnt=255.
- TIMEOUT=16, drawer 1 never asserts done:
  - obj_en[1] high exactly 16 cycles, then timeout_err=1.
  - Drawer 2 still runs.
  - timeout_err stays 1 on the next frame.
- obj_valid toggled from 4'b0001 to 4'b1000 during CLEAR -> only drawer 0 runs this frame, only drawer 3 next frame.
- reset=0 mid-DRAW (asynchronous, between clock edges):
  - wr_en and obj_en go 0 immediately. overrun_cnt=0.
  - After release, no activity until the next tick.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame scheduler slice.
package frame_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    DRAW,
    WAIT_FRAME
  } state_t;

  localparam int COORD_W_DEF = 11;

  localparam logic COLOR_BG  = 1'b0;
  localparam logic COLOR_OBJ = 1'b1;

endpackage

// File: rtl/frame_scheduler_obj_picker.sv
// Combinational search for the lowest enabled drawer index strictly above cur.
module obj_picker #(
  parameter int N_OBJ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_OBJ-1:0]       vmask,
  input  logic signed [IDX_W:0]  cur,
  output logic                   found,
  output logic [IDX_W-1:0]       next_idx
);

  logic [N_OBJ-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < N_OBJ; gi++) begin : g_cand
      // cur of -1 makes every index a candidate
      localparam logic signed [IDX_W:0] IDX = (IDX_W + 1)'(gi);
      assign cand[gi] = vmask[gi] && (IDX > cur);
    end
  endgenerate

  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int j = N_OBJ - 1; j >= 0; j--) begin
      if (cand[j]) begin
        found    = 1'b1;
        next_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: clear engine, then each enabled object drawer in index
// order, sharing one framebuffer write port.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int N_OBJ   = 4,
  parameter int COORD_W = COORD_W_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [N_OBJ-1:0]         obj_valid,
  output logic                     clr_en,
  input  logic                     clr_done,
  input  logic [COORD_W-1:0]       clr_x,
  input  logic [COORD_W-1:0]       clr_y,
  output logic [N_OBJ-1:0]         obj_en,
  input  logic [N_OBJ-1:0]         obj_done,
  input  logic [N_OBJ*COORD_W-1:0] obj_x,
  input  logic [N_OBJ*COORD_W-1:0] obj_y,
  output logic [COORD_W-1:0]       x,
  output logic [COORD_W-1:0]       y,
  output logic                     color,
  output logic                     wr_en,
  output logic                     busy,
  output logic [7:0]               overrun_cnt,
  output logic                     timeout_err
);

  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t                state_reg;
  logic [N_OBJ-1:0]      vmask_reg;
  logic signed [IDX_W:0] cur_reg;
  logic [IDX_W-1:0]      sel_reg;
  logic [TMO_W-1:0]      tmo_cnt_reg;
  logic                  pend_reg;
  logic [7:0]            overrun_cnt_reg;
  logic                  timeout_err_reg;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  busy_state;
  logic                  sel_done;

  obj_picker #(
    .N_OBJ (N_OBJ),
    .IDX_W (IDX_W)
  ) u_picker (
    .vmask    (vmask_reg),
    .cur      (cur_reg),
    .found    (pick_found),
    .next_idx (pick_idx)
  );

  assign busy_state = (state_reg == CLEAR) || (state_reg == SCAN) || (state_reg == DRAW);
  assign sel_done   = obj_done[sel_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      vmask_reg       <= '0;
      cur_reg         <= '1;
      sel_reg         <= '0;
      tmo_cnt_reg     <= '0;
      pend_reg        <= 1'b0;
      overrun_cnt_reg <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, WAIT_FRAME: begin
          if (frame_tick || pend_reg) begin
            state_reg <= CLEAR;
            vmask_reg <= obj_valid;
            pend_reg  <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_done) begin
            state_reg <= SCAN;
            cur_reg   <= '1;
          end
        end
        SCAN: begin
          if (pick_found) begin
            state_reg   <= DRAW;
            sel_reg     <= pick_idx;
            tmo_cnt_reg <= '0;
          end else begin
            state_reg <= WAIT_FRAME;
          end
        end
        DRAW: begin
          if (sel_done) begin
            state_reg <= SCAN;
            cur_reg   <= {1'b0, sel_reg};
          end else if (tmo_cnt_reg == TMO_LAST) begin
            // hung drawer: flag it and move on to the next one
            timeout_err_reg <= 1'b1;
            state_reg       <= SCAN;
            cur_reg         <= {1'b0, sel_reg};
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (busy_state && frame_tick) begin
        pend_reg <= 1'b1;
        if (overrun_cnt_reg != 8'hFF) begin
          overrun_cnt_reg <= overrun_cnt_reg + 8'd1;
        end
      end
    end
  end

  always_comb begin
    clr_en = 1'b0;
    obj_en = '0;
    wr_en  = 1'b0;
    color  = COLOR_BG;
    x      = '0;
    y      = '0;
    case (state_reg)
      CLEAR: begin
        clr_en = 1'b1;
        wr_en  = 1'b1;
        x      = clr_x;
        y      = clr_y;
      end
      DRAW: begin
        obj_en[sel_reg] = 1'b1;
        wr_en           = 1'b1;
        color           = COLOR_OBJ;
        x               = obj_x[sel_reg*COORD_W +: COORD_W];
        y               = obj_y[sel_reg*COORD_W +: COORD_W];
      end
      default: ;
    endcase
  end

  assign busy        = busy_state;
  assign overrun_cnt = overrun_cnt_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_frame_scheduler.sv
// Randomized bench: a per-frame plan of expected write-port cycles is built
// from the scheduling rules and compared against the scheduler every cycle.
module tb_frame_scheduler;

  localparam int N   = 4;
  localparam int CW  = 11;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_tick = 1'b0;
  logic [N-1:0]  obj_valid = '0;
  logic          clr_done = 1'b0;
  logic [CW-1:0] clr_x = '0;
  logic [CW-1:0] clr_y = '0;
  logic [N-1:0]  obj_done = '0;
  logic [N*CW-1:0] obj_x = '0;
  logic [N*CW-1:0] obj_y = '0;
  logic          clr_en, color, wr_en, busy, timeout_err;
  logic [N-1:0]  obj_en;
  logic [CW-1:0] x, y;
  logic [7:0]    overrun_cnt;

  frame_scheduler #(.N_OBJ(N), .COORD_W(CW), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .obj_valid   (obj_valid),
    .clr_en      (clr_en),
    .clr_done    (clr_done),
    .clr_x       (clr_x),
    .clr_y       (clr_y),
    .obj_en      (obj_en),
    .obj_done    (obj_done),
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .x           (x),
    .y           (y),
    .color       (color),
    .wr_en       (wr_en),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           busy;
    bit           wr;
    bit           clr;
    logic [N-1:0] en;
    bit           color;
    int           src;
    bit           abort;
  } rec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t plan_q[$];
  int   exp_cnt = 0;
  bit   exp_err = 1'b0;
  bit   pending = 1'b0;
  bit   hang_on = 1'b0;
  int   lc = 1;
  int   dur[N];
  int   ccnt = 0;
  int   dcnt[N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t mk(bit b, bit w, bit c, logic [N-1:0] e, bit col, int s, bit a);
    rec_t r;
    r.busy = b; r.wr = w; r.clr = c; r.en = e; r.color = col; r.src = s; r.abort = a;
    return r;
  endfunction

  // One frame: clear for lc cycles, a scan slot, then each enabled drawer
  // (capped at TMO cycles) followed by its own scan slot.
  task automatic build_plan(input logic [N-1:0] v);
    int n;
    lc = $urandom_range(5, 1);
    for (int j = 0; j < N; j++) begin
      int k = $urandom_range(9);
      if (k == 0 && hang_on) dur[j] = 0;
      else if (k == 1)       dur[j] = TMO;
      else if (k == 2)       dur[j] = TMO + 1;
      else                   dur[j] = $urandom_range(6, 1);
    end
    for (int c = 0; c < lc; c++) plan_q.push_back(mk(1, 1, 1, '0, 0, -1, 0));
    plan_q.push_back(mk(1, 0, 0, '0, 0, -1, 0));
    for (int j = 0; j < N; j++) begin
      if (v[j]) begin
        bit hung = (dur[j] == 0) || (dur[j] > TMO);
        n = hung ? TMO : dur[j];
        for (int c = 0; c < n; c++)
          plan_q.push_back(mk(1, 1, 0, N'(1 << j), 1, j, hung && (c == n - 1)));
        plan_q.push_back(mk(1, 0, 0, '0, 0, -1, 0));
      end
    end
  endtask

  task automatic step(input int tick_pct, input int vchg_pct, input bit vzero);
    rec_t r;
    logic [2*CW-1:0] exy;
    @(negedge clk);
    if (plan_q.size() > 0) r = plan_q.pop_front();
    else                   r = mk(0, 0, 0, '0, 0, -1, 0);
    $display("cyc t=%0t busy=%0b wr=%0b clr=%0b en=%b ovr=%0d terr=%0b",
             $time, busy, wr_en, clr_en, obj_en, overrun_cnt, timeout_err);
    chk("ctl", {busy, wr_en, clr_en, obj_en}, {r.busy, r.wr, r.clr, r.en});
    if (r.wr) begin
      chk("color", color, r.color);
      if (r.src < 0) exy = {clr_x, clr_y};
      else           exy = {obj_x[r.src*CW +: CW], obj_y[r.src*CW +: CW]};
      chk("xy", {x, y}, exy);
    end
    chk("ovr", overrun_cnt, 64'(exp_cnt));
    chk("terr", timeout_err, exp_err);

    // engine responders react to the enables they see
    if (clr_en) ccnt++; else ccnt = 0;
    clr_done = clr_en ? (ccnt == lc) : ($urandom_range(3) == 0);
    for (int j = 0; j < N; j++) begin
      if (obj_en[j]) dcnt[j]++; else dcnt[j] = 0;
      obj_done[j] = obj_en[j] ? (dur[j] != 0 && dcnt[j] == dur[j]) : ($urandom_range(2) == 0);
    end
    clr_x = CW'($urandom); clr_y = CW'($urandom);
    obj_x = {$urandom, $urandom}; obj_y = {$urandom, $urandom};
    frame_tick = ($urandom_range(99) < tick_pct);
    if ($urandom_range(99) < vchg_pct) obj_valid = vzero ? '0 : N'($urandom);

    if (r.abort) exp_err = 1'b1;
    if (r.busy) begin
      if (frame_tick) begin
        pending = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end
    end else if (frame_tick || pending) begin
      pending = 1'b0;
      build_plan(obj_valid);
    end
  endtask

  task automatic model_reset();
    plan_q.delete();
    exp_cnt = 0; exp_err = 1'b0; pending = 1'b0; ccnt = 0;
    for (int j = 0; j < N; j++) begin dcnt[j] = 0; dur[j] = 1; end
  endtask

  initial begin
    bit found;
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, wr_en, clr_en, obj_en}, '0);
    chk("rst_xyc", {x, y, color}, '0);
    chk("rst_ovr", overrun_cnt, '0);
    chk("rst_terr", timeout_err, '0);
    reset = 1'b1;

    hang_on = 1'b0;
    repeat (400) step(4, 30, 1'b0);
    repeat (150) step(4, 100, 1'b1);
    hang_on = 1'b1;
    repeat (500) step(5, 30, 1'b0);
    repeat (500) step(100, 30, 1'b0);
    chk("ovr_sat", overrun_cnt, 64'd255);

    // asynchronous reset in the middle of a draw
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      step(5, 30, 1'b0);
      if (obj_en != '0) found = 1'b1;
    end
    chk("draw_seen", found, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("arst_ctl", {busy, wr_en, clr_en, obj_en}, '0);
    chk("arst_ovr", overrun_cnt, '0);
    chk("arst_terr", timeout_err, '0);
    frame_tick = 1'b0; clr_done = 1'b0; obj_done = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) step(0, 30, 1'b0);
    repeat (400) step(4, 30, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
